// File: rtl/division_result_sign_restore_pkg.sv
`default_nettype none
// ============================================================================
// division_result_sign_restore_pkg : shared types/constants for sign restore
// Rev 1.0
// ============================================================================
package division_result_sign_restore_pkg;

    localparam int c_WIDTH_DEFAULT = 4;
    localparam int c_CNT_W         = $clog2(c_WIDTH_DEFAULT + 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_CONV = 2'd1,
        S_DONE = 2'd2
    } state_t;

    function automatic logic f_quot_negative(input logic sign_a, input logic sign_b);
        return sign_a ^ sign_b;
    endfunction

endpackage
`default_nettype wire

// File: rtl/division_serial_negate.sv
`default_nettype none
// ============================================================================
// division_serial_negate : bit-serial LSB-first two's-complement cell
// Rev 1.0
// ============================================================================
module division_serial_negate (
    input  logic clk,
    input  logic rst,
    input  logic i_load,
    input  logic i_neg_en,
    input  logic i_bit_in,
    output logic o_bit_out,
    output logic o_carry
);

    logic r_carry;

    // Carry seeds to 1 (the "+1") and only survives while the input bits are zero.
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_carry <= 1'b0;
        end else if (i_load) begin
            r_carry <= 1'b1;
        end else begin
            r_carry <= ~i_bit_in & r_carry;
        end
    end

    assign o_bit_out = i_neg_en ? (~i_bit_in ^ r_carry) : i_bit_in;
    assign o_carry   = r_carry;

endmodule
`default_nettype wire

// File: rtl/division_result_sign_restore.sv
`default_nettype none
// ============================================================================
// division_result_sign_restore : re-applies quotient/remainder signs serially
// Rev 1.0
// ============================================================================
module division_result_sign_restore
    import division_result_sign_restore_pkg::*;
#(
    parameter int WIDTH = c_WIDTH_DEFAULT
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_start,
    input  logic [WIDTH-1:0] i_quot_mag,
    input  logic [WIDTH-1:0] i_rem_mag,
    input  logic             i_sign_a,
    input  logic             i_sign_b,
    input  logic             i_div_by_zero,
    output logic [WIDTH-1:0] o_result_q,
    output logic [WIDTH-1:0] o_result_r,
    output logic             o_busy,
    output logic             o_done,
    output logic             o_overflow,
    output logic             o_err
);

    localparam int                      c_BIT_CNT_W = $clog2(WIDTH + 1);
    localparam logic [c_BIT_CNT_W-1:0]  c_CNT_LAST  = c_BIT_CNT_W'(WIDTH - 1);
    localparam logic [c_BIT_CNT_W-1:0]  c_CNT_ONE   = c_BIT_CNT_W'(1);

    state_t                 r_state;
    state_t                 w_state_nxt;
    logic                   w_load;
    logic                   w_err_go;
    logic                   w_shift;
    logic                   w_finish;

    logic [WIDTH-1:0]       r_q_sh;
    logic [WIDTH-1:0]       r_r_sh;
    logic                   r_q_neg;
    logic                   r_r_neg;
    logic                   r_ovf_cap;
    logic                   r_err_cap;
    logic [c_BIT_CNT_W-1:0] r_cnt;

    logic [WIDTH-1:0]       r_result_q;
    logic [WIDTH-1:0]       r_result_r;
    logic                   r_done;
    logic                   r_overflow;
    logic                   r_err;

    logic                   w_q_bit;
    logic                   w_r_bit;
    logic                   w_q_carry_unused;
    logic                   w_r_carry_unused;

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_load      = 1'b0;
        w_err_go    = 1'b0;
        w_shift     = 1'b0;
        w_finish    = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (i_start) begin
                    if (i_div_by_zero) begin
                        w_err_go    = 1'b1;
                        w_state_nxt = S_DONE;
                    end else begin
                        w_load      = 1'b1;
                        w_state_nxt = S_CONV;
                    end
                end
            end
            S_CONV: begin
                w_shift = 1'b1;
                if (r_cnt == c_CNT_LAST) begin
                    w_state_nxt = S_DONE;
                end
            end
            S_DONE: begin
                w_finish    = 1'b1;
                w_state_nxt = S_IDLE;
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    division_serial_negate u_neg_q (
        .clk      (clk),
        .rst      (rst),
        .i_load   (w_load),
        .i_neg_en (r_q_neg),
        .i_bit_in (r_q_sh[0]),
        .o_bit_out(w_q_bit),
        .o_carry  (w_q_carry_unused)
    );

    division_serial_negate u_neg_r (
        .clk      (clk),
        .rst      (rst),
        .i_load   (w_load),
        .i_neg_en (r_r_neg),
        .i_bit_in (r_r_sh[0]),
        .o_bit_out(w_r_bit),
        .o_carry  (w_r_carry_unused)
    );

    // Converted bits enter at the MSB, so after WIDTH shifts the register holds the result.
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_q_sh     <= '0;
            r_r_sh     <= '0;
            r_q_neg    <= 1'b0;
            r_r_neg    <= 1'b0;
            r_ovf_cap  <= 1'b0;
            r_err_cap  <= 1'b0;
            r_cnt      <= '0;
            r_result_q <= '0;
            r_result_r <= '0;
            r_done     <= 1'b0;
            r_overflow <= 1'b0;
            r_err      <= 1'b0;
        end else begin
            r_done <= w_finish;
            if (w_load) begin
                r_q_sh    <= i_quot_mag;
                r_r_sh    <= i_rem_mag;
                r_q_neg   <= f_quot_negative(i_sign_a, i_sign_b);
                r_r_neg   <= i_sign_a;
                r_ovf_cap <= ~f_quot_negative(i_sign_a, i_sign_b) & i_quot_mag[WIDTH-1];
                r_err_cap <= 1'b0;
                r_cnt     <= '0;
            end else if (w_err_go) begin
                r_q_sh    <= '0;
                r_r_sh    <= '0;
                r_ovf_cap <= 1'b0;
                r_err_cap <= 1'b1;
            end else if (w_shift) begin
                r_q_sh <= {w_q_bit, r_q_sh[WIDTH-1:1]};
                r_r_sh <= {w_r_bit, r_r_sh[WIDTH-1:1]};
                r_cnt  <= r_cnt + c_CNT_ONE;
            end
            if (w_finish) begin
                r_result_q <= r_q_sh;
                r_result_r <= r_r_sh;
                r_overflow <= r_ovf_cap;
                r_err      <= r_err_cap;
            end
        end
    end

    assign o_result_q = r_result_q;
    assign o_result_r = r_result_r;
    assign o_busy     = (r_state != S_IDLE);
    assign o_done     = r_done;
    assign o_overflow = r_overflow;
    assign o_err      = r_err;

endmodule
`default_nettype wire
